// File: rtl/pill_miss_recorder.sv
`default_nettype none
// ============================================================================
// Module      : pill_miss_recorder
// Description : N-channel due-window tracker. Records takes and misses per
//               channel, keeps saturating miss counts and a consecutive-miss
//               alarm, and acknowledges takes back to the next-pill monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module pill_miss_recorder #(
    parameter int N_PILLS      = 3,
    parameter int DUR_W        = 4,
    parameter int MISS_W       = 4,
    parameter int TOT_W        = 8,
    parameter int GRACE_TICKS  = 0,
    parameter int ALARM_THRESH = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clearCounts,
    input  logic                       running,
    input  logic                       tick,
    input  logic                       takePill,
    input  logic [N_PILLS*DUR_W-1:0]   pillDuration,
    output logic [N_PILLS-1:0]         dueLed,
    output logic [N_PILLS-1:0]         ackTaken,
    output logic [N_PILLS*MISS_W-1:0]  missCounts,
    output logic [TOT_W-1:0]           totalMisses,
    output logic [N_PILLS-1:0]         missAlarm
);

    localparam int GW = (GRACE_TICKS > 0) ? $clog2(GRACE_TICKS + 1) : 1;
    localparam int CW = $clog2(ALARM_THRESH + 1);
    localparam int PW = $clog2(N_PILLS + 1);
    localparam int SW = TOT_W + PW;

    localparam logic [GW-1:0]     C_GRACE_LAST = GW'((GRACE_TICKS > 0) ? GRACE_TICKS - 1 : 0);
    localparam logic [CW-1:0]     C_THRESH     = CW'(ALARM_THRESH);
    localparam logic [MISS_W-1:0] C_MISS_MAX   = {MISS_W{1'b1}};
    localparam logic [TOT_W-1:0]  C_TOT_MAX    = {TOT_W{1'b1}};
    localparam logic              C_GRACE_EN   = (GRACE_TICKS != 0);

    localparam logic [1:0] S_WAIT   = 2'd0;
    localparam logic [1:0] S_DUE    = 2'd1;
    localparam logic [1:0] S_TAKEN  = 2'd2;
    localparam logic [1:0] S_MISSED = 2'd3;

    logic [N_PILLS-1:0] w_miss_vec;

    generate
        for (genvar i = 0; i < N_PILLS; i++) begin : g_ch
            logic [1:0]        r_state;
            logic [1:0]        w_next;
            logic [GW-1:0]     r_grace;
            logic [MISS_W-1:0] r_miss;
            logic [CW-1:0]     r_consec;
            logic [CW-1:0]     w_consec_inc;
            logic              r_due;
            logic              r_ack;
            logic              r_alarm;
            logic              w_dur_zero;
            logic              w_grace_exp;
            logic              w_take;
            logic              w_miss;

            assign w_dur_zero   = (pillDuration[i*DUR_W +: DUR_W] == '0);
            assign w_grace_exp  = C_GRACE_EN && tick && running && (r_grace == C_GRACE_LAST);
            assign w_consec_inc = r_consec + CW'(1);

            // Take outranks both reload and grace expiry inside the window.
            always_comb begin
                w_next = r_state;
                w_take = 1'b0;
                w_miss = 1'b0;
                case (r_state)
                    S_WAIT: begin
                        if (w_dur_zero && running) w_next = S_DUE;
                    end
                    S_DUE: begin
                        if (takePill) begin
                            w_next = S_TAKEN;
                            w_take = 1'b1;
                        end else if (!w_dur_zero || w_grace_exp) begin
                            w_next = S_MISSED;
                            w_miss = 1'b1;
                        end
                    end
                    S_TAKEN: begin
                        if (!w_dur_zero) w_next = S_WAIT;
                    end
                    S_MISSED: begin
                        if (!w_dur_zero) w_next = S_WAIT;
                    end
                    default: w_next = S_WAIT;
                endcase
            end

            always_ff @(posedge clk) begin
                if (reset || clearCounts) begin
                    r_state  <= S_WAIT;
                    r_grace  <= '0;
                    r_miss   <= '0;
                    r_consec <= '0;
                    r_due    <= 1'b0;
                    r_ack    <= 1'b0;
                    r_alarm  <= 1'b0;
                end else begin
                    r_state <= w_next;
                    r_due   <= (w_next == S_DUE);
                    r_ack   <= (w_next == S_TAKEN);
                    if (r_state == S_WAIT) begin
                        r_grace <= '0;
                    end else if (r_state == S_DUE && tick && running) begin
                        r_grace <= r_grace + GW'(1);
                    end
                    if (w_take) begin
                        r_consec <= '0;
                        r_alarm  <= 1'b0;
                    end else if (w_miss) begin
                        if (r_miss != C_MISS_MAX) r_miss <= r_miss + MISS_W'(1);
                        if (r_consec != C_THRESH) r_consec <= w_consec_inc;
                        if (r_consec == C_THRESH || w_consec_inc == C_THRESH) r_alarm <= 1'b1;
                    end
                end
            end

            assign dueLed[i]                       = r_due;
            assign ackTaken[i]                     = r_ack;
            assign missAlarm[i]                    = r_alarm;
            assign missCounts[i*MISS_W +: MISS_W]  = r_miss;
            assign w_miss_vec[i]                   = w_miss;
        end
    endgenerate

    logic [PW-1:0]    w_pop;
    logic [SW-1:0]    w_sum;
    logic [TOT_W-1:0] r_total;

    always_comb begin
        w_pop = '0;
        for (int k = 0; k < N_PILLS; k++) begin
            w_pop = w_pop + PW'(w_miss_vec[k]);
        end
        w_sum = SW'(r_total) + SW'(w_pop);
    end

    // Aggregate saturates independently of the per-channel counters.
    always_ff @(posedge clk) begin
        if (reset || clearCounts) begin
            r_total <= '0;
        end else if (w_sum > SW'(C_TOT_MAX)) begin
            r_total <= C_TOT_MAX;
        end else begin
            r_total <= w_sum[TOT_W-1:0];
        end
    end

    assign totalMisses = r_total;

endmodule
`default_nettype wire

// File: tb/tb_pill_miss_recorder.sv
`default_nettype none
// ============================================================================
// Module      : tb_pill_miss_recorder
// Description : Directed scoreboard bench for pill_miss_recorder (grace 0 and 2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pill_miss_recorder;

    logic        clk;
    logic        reset;
    logic        clearCounts;
    logic        running;
    logic        tick;
    logic        takePill;
    logic [11:0] dur;

    logic [2:0]  due0, ack0, al0, due1, ack1, al1;
    logic [11:0] mc0, mc1;
    logic [7:0]  tot0, tot1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;
    sb_t sbq[$];

    pill_miss_recorder #(
        .N_PILLS(3), .DUR_W(4), .MISS_W(4), .TOT_W(8), .GRACE_TICKS(0), .ALARM_THRESH(3)
    ) dut0 (
        .clk(clk), .reset(reset), .clearCounts(clearCounts), .running(running),
        .tick(tick), .takePill(takePill), .pillDuration(dur),
        .dueLed(due0), .ackTaken(ack0), .missCounts(mc0), .totalMisses(tot0), .missAlarm(al0)
    );

    pill_miss_recorder #(
        .N_PILLS(3), .DUR_W(4), .MISS_W(4), .TOT_W(8), .GRACE_TICKS(2), .ALARM_THRESH(3)
    ) dut1 (
        .clk(clk), .reset(reset), .clearCounts(clearCounts), .running(running),
        .tick(tick), .takePill(takePill), .pillDuration(dur),
        .dueLed(due1), .ackTaken(ack1), .missCounts(mc1), .totalMisses(tot1), .missAlarm(al1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [31:0] v);
        sb_t e;
        e.tag = tag;
        e.exp = v;
        sbq.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        sb_t e;
        total++;
        if (sbq.size() == 0) begin
            bad++;
            $error("FAIL sb_empty: observed=%0h expected=<none>", obs);
            return;
        end
        e = sbq.pop_front();
        assert (obs === e.exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", e.tag, obs, e.exp);
        end
    endtask

    initial begin
        reset = 1'b1; clearCounts = 1'b0; running = 1'b0;
        tick = 1'b0; takePill = 1'b0; dur = 12'h555;
        cyc(); cyc();
        reset = 1'b0;
        push("rst_due", 0); push("rst_ack", 0); push("rst_mc", 0);
        push("rst_tot", 0); push("rst_alarm", 0);
        cyc();
        chk(32'(due0)); chk(32'(ack0)); chk(32'(mc0)); chk(32'(tot0)); chk(32'(al0));

        // Channel 0 counts down and reloads without a take.
        running = 1'b1;
        dur[3:0] = 4'd2; cyc();
        dur[3:0] = 4'd1; cyc();
        dur[3:0] = 4'd0;
        push("t1_due_on", 3'b001);
        cyc(); chk(32'(due0));
        push("t1_due_hold", 3'b001); push("t1_ack_hold", 0);
        cyc(); chk(32'(due0)); chk(32'(ack0));
        dur[3:0] = 4'd5;
        push("t1_due_off", 0); push("t1_mc", 12'h001); push("t1_tot", 1); push("t1_ack", 0);
        cyc(); chk(32'(due0)); chk(32'(mc0)); chk(32'(tot0)); chk(32'(ack0));
        cyc();

        // Channel 1 taken inside its window.
        dur[7:4] = 4'd0;
        push("t2_due", 3'b010);
        cyc(); chk(32'(due0));
        takePill = 1'b1;
        push("t2_ack", 3'b010); push("t2_due_off", 0);
        cyc(); takePill = 1'b0;
        chk(32'(ack0)); chk(32'(due0));
        push("t2_ack_hold", 3'b010);
        cyc(); chk(32'(ack0));
        dur[7:4] = 4'd5;
        push("t2_ack_rel", 0); push("t2_mc", 12'h001); push("t2_alarm", 0);
        cyc(); chk(32'(ack0)); chk(32'(mc0)); chk(32'(al0));

        // Second and third consecutive channel 0 misses.
        dur[3:0] = 4'd0; cyc();
        dur[3:0] = 4'd5;
        push("t3_alarm2", 0); push("t3_mc2", 12'h002);
        cyc(); chk(32'(al0)); chk(32'(mc0));
        cyc();
        dur[3:0] = 4'd0; cyc();
        dur[3:0] = 4'd5;
        push("t3_alarm3", 3'b001); push("t3_mc3", 12'h003); push("t3_tot3", 3);
        cyc(); chk(32'(al0)); chk(32'(mc0)); chk(32'(tot0));
        cyc();
        dur[3:0] = 4'd0; cyc();
        takePill = 1'b1;
        push("t3_alarm_clr", 0); push("t3_ack", 3'b001);
        cyc(); takePill = 1'b0;
        chk(32'(al0)); chk(32'(ack0));
        dur[3:0] = 4'd5; cyc();

        // All channels miss in the same cycle.
        dur = 12'h000;
        push("t4_due_all", 3'b111);
        cyc(); chk(32'(due0));
        dur = 12'h555;
        push("t4_tot", 6); push("t4_mc", 12'h114);
        cyc(); chk(32'(tot0)); chk(32'(mc0));
        cyc();

        // Zero duration while stopped is ignored.
        running = 1'b0; dur = 12'h000;
        cyc(); cyc();
        push("t5_due", 0); push("t5_tot", 6);
        cyc(); chk(32'(due0)); chk(32'(tot0));
        dur = 12'h555; running = 1'b1; cyc();

        // Grace expiry on channel 2 of the GRACE_TICKS=2 instance.
        dur[11:8] = 4'd0; cyc();
        push("g_due1_t1", 3'b100);
        tick = 1'b1; cyc(); tick = 1'b0;
        chk(32'(due1));
        push("g_mc1_t2", 2); push("g_due1_t2", 0); push("g_due0_t2", 3'b100);
        tick = 1'b1; cyc(); tick = 1'b0;
        chk(32'(mc1[11:8])); chk(32'(due1)); chk(32'(due0));
        for (int k = 0; k < 10; k++) begin
            tick = 1'b1; cyc(); tick = 1'b0; cyc();
        end
        push("g_mc1_hold", 2); push("g_due0_hold", 3'b100);
        cyc(); chk(32'(mc1[11:8])); chk(32'(due0));
        dur[11:8] = 4'd5;
        push("g_mc0_reload", 2); push("g_mc1_reload", 2); push("g_tot0", 7); push("g_tot1", 7);
        cyc(); chk(32'(mc0[11:8])); chk(32'(mc1[11:8])); chk(32'(tot0)); chk(32'(tot1));
        cyc();

        // Take and grace expiry together: take wins.
        dur[11:8] = 4'd0; cyc();
        tick = 1'b1; cyc();
        takePill = 1'b1;
        push("tg_ack1", 3'b100); push("tg_mc1", 2); push("tg_tot1", 7);
        cyc(); tick = 1'b0; takePill = 1'b0;
        chk(32'(ack1)); chk(32'(mc1[11:8])); chk(32'(tot1));
        dur[11:8] = 4'd5; cyc();

        // Clear, then saturate channel 0.
        clearCounts = 1'b1;
        push("clr_mc", 0); push("clr_tot", 0); push("clr_alarm", 0);
        cyc(); clearCounts = 1'b0;
        chk(32'(mc0)); chk(32'(tot0)); chk(32'(al0));
        for (int k = 0; k < 20; k++) begin
            dur[3:0] = 4'd0; cyc();
            dur[3:0] = 4'd5; cyc(); cyc();
        end
        push("sat_mc0", 12'h00F); push("sat_tot0", 20); push("sat_alarm", 3'b001); push("sat_tot1", 20);
        cyc(); chk(32'(mc0)); chk(32'(tot0)); chk(32'(al0)); chk(32'(tot1));

        // clearCounts while a window is open.
        dur[3:0] = 4'd0;
        push("cd_due", 3'b001);
        cyc(); chk(32'(due0));
        clearCounts = 1'b1;
        push("cd_due_off", 0); push("cd_mc", 0); push("cd_tot", 0); push("cd_alarm", 0);
        cyc(); clearCounts = 1'b0; dur[3:0] = 4'd5;
        chk(32'(due0)); chk(32'(mc0)); chk(32'(tot0)); chk(32'(al0));
        cyc();

        // Reset while a channel holds its acknowledge.
        dur[7:4] = 4'd0; cyc();
        takePill = 1'b1;
        push("rt_ack", 3'b010);
        cyc(); takePill = 1'b0;
        chk(32'(ack0));
        reset = 1'b1;
        push("rt_ack_clr", 0); push("rt_due", 0);
        cyc(); reset = 1'b0;
        chk(32'(ack0)); chk(32'(due0));

        if (sbq.size() != 0) begin
            total++;
            bad++;
            $error("FAIL sb_leftover: observed=%0d expected=0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pill_miss_recorder.md
Name: pill_miss_recorder

Overview:
Parametrised, N-channel successor to the three-pill taken recorder. For each pill channel it watches the countdown duration from the pill timer and opens a "due" window when the duration reaches zero. It records whether the patient pressed take within the window, counts misses with saturation, and raises a per-channel alarm after repeated consecutive misses. Outputs feed the next-pill monitor (acknowledge/reload) and the RAM logging path (packed miss counts).

Parameters:
N_PILLS, 3, number of pill channels (1..8)
DUR_W, 4, width of each channel's duration field
MISS_W, 4, width of each per-channel miss counter (saturating)
TOT_W, 8, width of the aggregate miss counter (saturating)
GRACE_TICKS, 0, ticks a due window stays open before it is declared missed; 0 = window closes only when the timer reloads
ALARM_THRESH, 3, number of consecutive misses that asserts the channel alarm (>=1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
clearCounts  in  1  load-from-ROM strobe: zero all counters
running  in  1  high when the system is in the run state
tick  in  1  one-cycle 1 Hz strobe
takePill  in  1  one-cycle pulse from the debounced start/take button
pillDuration  in  N_PILLS*DUR_W  current countdown per channel, channel i at [i*DUR_W +: DUR_W]
dueLed  out  N_PILLS  high while the channel's window is open
ackTaken  out  N_PILLS  to next-pill monitor: reload duration
missCounts  out  N_PILLS*MISS_W  packed per-channel miss counts, same packing as pillDuration
totalMisses  out  TOT_W  aggregate misses across all channels
missAlarm  out  N_PILLS  consecutive-miss alarm per channel

Behaviour:
- Reset: all channel FSMs go to WAIT; all outputs are 0; all counters are 0. Reset has priority over every other input.
- clearCounts (when not in reset): zero missCounts, totalMisses, the consecutive counters and missAlarm; FSMs go to WAIT. Takes priority over take and miss events in the same cycle.
- Per-channel FSM, all outputs registered (1-cycle latency from the causing input):
  - WAIT: when dur==0 and running=1, go to DUE, clear the grace counter, set dueLed=1.
    - dur==0 with running=0 is ignored, so the start/reset state never counts a miss.
  - DUE: dueLed=1. Transitions, in priority order:
    - takePill=1: go to TAKEN, set consecutive=0, deassert missAlarm.
    - dur!=0 (timer reloaded without a take), or GRACE_TICKS!=0 and the grace count reaches GRACE_TICKS on a tick: go to MISSED. missCount is incremented exactly once, saturating at 2^MISS_W-1. consecutive is incremented, saturating at ALARM_THRESH.
    - Otherwise stay; the grace counter increments on tick only while running=1.
  - TAKEN: ackTaken=1 and dueLed=0. ackTaken is held until dur!=0, then go to WAIT.
    - TAKEN persists while running=0.
  - MISSED: dueLed=0. When dur!=0, go to WAIT.
    - A dur of 0 that persists does not re-enter DUE or recount.
- Take while a channel is not in DUE has no effect on that channel. One takePill acknowledges every channel currently in DUE.
- missAlarm[i] is set when consecutive reaches ALARM_THRESH. It stays sticky until a take on that channel, clearCounts, or reset.
- totalMisses adds, in one cycle, the number of channels entering MISSED that cycle (popcount). It saturates at 2^TOT_W-1 and is not limited by per-channel saturation.
- Take and grace expiry in the same cycle: the take wins and no miss is counted.
- 1-second interval case: dur is 0 for one tick, then reloads. DUE is entered, then MISSED on reload if there was no take. A take in that window is honoured.
- Grace counter width is clog2(GRACE_TICKS+1), minimum 1.

Test Plan:
- N=3, DUR_W=4, GRACE=0: drive ch0 dur 2,1,0 with running=1, no take, then reload dur=5. Expect dueLed[0]=1 for the zero period, missCounts[3:0]=1, totalMisses=1, ackTaken[0] never high.
- Ch1 dur=0 and takePill pulse: ackTaken[1]=1 on the next cycle and held until dur[7:4]!=0. dueLed[1] drops, the miss count is unchanged and no alarm is raised.
- GRACE_TICKS=2, ch2 dur held at 0: on the 2nd tick, missCounts[11:8] increments by exactly 1. Holding dur=0 for 10 more ticks gives no further increment.
- Three consecutive ch0 misses: missAlarm[0]=1 after the 3rd. The next take clears it. All three channels missing in the same cycle gives totalMisses+3.
- Saturation: 20 misses on ch0 with MISS_W=4 gives missCounts ch0=15 while totalMisses=20. clearCounts mid-DUE zeroes everything, FSM goes to WAIT, dueLed=0.
- dur=0 with running=0 produces no DUE and no miss. Reset asserted mid-TAKEN clears ackTaken on the next cycle.
